gray_frame_ctrl: RTL and testbench

Frame sequencer for the RGB-to-grayscale stage between the camera RGB FIFO (24-bit) and the grayscale FIFO (8-bit). On `start` it moves exactly WIDTH*HEIGHT pixels through a registered (r+g+b)/3 conversion. It obeys both FIFO handshakes, so it never reads from an empty FIFO or writes to a full one. It tracks column and row counts and pulses `frame_done` once the last gray pixel has been written, then waits for the next `start`.

---
 rtl/gray_pkg.sv | 20 ++
 rtl/gray_pix.sv | 11 +
 rtl/gray_frame_ctrl.sv | 125 ++++++++++++
 tb/tb_gray_frame_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and pixel arithmetic for the RGB-to-grayscale frame stage.
package gray_pkg;

  localparam int RGB_W  = 24;
  localparam int GRAY_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // The 10-bit sum cannot overflow (3*255 = 765), and 765/3 = 255 fits in 8 bits.
  function automatic logic [GRAY_W-1:0] rgb2gray(input logic [RGB_W-1:0] rgb);
    logic [9:0] sum;
    sum = 10'(rgb[23:16]) + 10'(rgb[15:8]) + 10'(rgb[7:0]);
    return GRAY_W'(sum / 10'd3);
  endfunction

endpackage

// File: rtl/gray_pix.sv
// Combinational RGB-to-gray conversion, kept separate so the arithmetic is checked on its own.
module gray_pix
  import gray_pkg::*;
(
  input  logic [RGB_W-1:0]  rgb_i,
  output logic [GRAY_W-1:0] gray_o
);

  assign gray_o = rgb2gray(rgb_i);

endmodule

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer: pulls WIDTH*HEIGHT RGB pixels, converts them to gray and
// pushes them to the gray FIFO, honouring both FIFO handshakes.
module gray_frame_ctrl
  import gray_pkg::*;
#(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  parameter int CNT_W  = 16
)
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              in_rd_en,
  input  logic              in_empty,
  input  logic [RGB_W-1:0]  in_dout,
  output logic              out_wr_en,
  input  logic              out_full,
  output logic [GRAY_W-1:0] out_din,
  output logic [CNT_W-1:0]  col,
  output logic [CNT_W-1:0]  row
);

  state_e              state_q;
  logic                busy_q;
  logic                frameDone_q;
  logic                outValid_q;
  logic [GRAY_W-1:0]   outDin_q;
  logic [CNT_W-1:0]    col_q;
  logic [CNT_W-1:0]    row_q;
  logic [CNT_W-1:0]    col_d;
  logic [CNT_W-1:0]    row_d;
  logic [GRAY_W-1:0]   pixGray;
  logic                rdEn;
  logic                wrEn;
  logic                colLast;
  logic                rowLast;

  gray_pix uPix (
    .rgb_i  (in_dout),
    .gray_o (pixGray)
  );

  assign colLast = (col_q == CNT_W'(WIDTH - 1));
  assign rowLast = (row_q == CNT_W'(HEIGHT - 1));

  // A full gray FIFO only blocks reads while the output register is occupied.
  assign wrEn = outValid_q & ~out_full;
  assign rdEn = (state_q == S_RUN) & ~in_empty & (~outValid_q | ~out_full);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (rdEn) begin
      if (colLast) begin
        col_d = '0;
        row_d = rowLast ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      outValid_q  <= 1'b0;
      outDin_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      frameDone_q <= 1'b0;
      col_q       <= col_d;
      row_q       <= row_d;

      if (rdEn) begin
        outDin_q   <= pixGray;
        outValid_q <= 1'b1;
      end else if (wrEn) begin
        outValid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        S_RUN: begin
          if (rdEn && colLast && rowLast) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The output register now holds the final pixel of the frame.
          if (wrEn) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = frameDone_q;
  assign out_din    = outDin_q;
  assign col        = col_q;
  assign row        = row_q;
  assign in_rd_en   = rdEn;
  assign out_wr_en  = wrEn;

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Self-checking bench for gray_frame_ctrl on a 4x2 frame against a pixel-count reference model.
module tb_gray_frame_ctrl;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int TOTAL = W * H;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic        in_rd_en;
  logic        in_empty;
  logic [23:0] in_dout;
  logic        out_wr_en;
  logic        out_full;
  logic [7:0]  out_din;
  logic [15:0] col;
  logic [15:0] row;

  gray_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .in_rd_en   (in_rd_en),
    .in_empty   (in_empty),
    .in_dout    (in_dout),
    .out_wr_en  (out_wr_en),
    .out_full   (out_full),
    .out_din    (out_din),
    .col        (col),
    .row        (row)
  );

  always #5 clock = ~clock;

  logic [23:0] fifoQ[$];
  logic [7:0]  pendQ[$];
  logic [7:0]  wrLog[$];
  bit          mActive;
  bit          expDone;
  bit          starve;
  bit          fullReq;
  bit          startReq;
  int          mRead;
  int          mWritten;
  int          framesStarted;
  int          doneCount;
  int          writeCount;
  int          testsRun;
  int          failCount;

  function automatic logic [7:0] refGray(logic [23:0] p);
    int s;
    s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    return 8'(s / 3);
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic loadRandom(int n);
    for (int i = 0; i < n; i++) fifoQ.push_back(24'($urandom));
  endtask

  // One clock: drive inputs at negedge, check handshakes, advance the model at posedge, check state.
  task automatic applyStimulus();
    bit expRd;
    bit expWr;
    bit wasActive;
    @(negedge clock);
    start    = startReq;
    out_full = fullReq;
    in_empty = (fifoQ.size() == 0) || starve;
    in_dout  = (fifoQ.size() != 0) ? fifoQ[0] : 24'($urandom);
    #1;
    expRd = mActive && (mRead < TOTAL) && !in_empty && (pendQ.size() == 0 || !out_full);
    expWr = (pendQ.size() != 0) && !out_full;
    checkOutput("in_rd_en", 32'(in_rd_en), 32'(expRd));
    checkOutput("out_wr_en", 32'(out_wr_en), 32'(expWr));
    if (expWr) checkOutput("out_din_at_write", 32'(out_din), 32'(pendQ[0]));
    if (out_wr_en) begin
      wrLog.push_back(out_din);
      writeCount++;
    end
    @(posedge clock);
    wasActive = mActive;
    expDone   = 1'b0;
    if (expWr) begin
      pendQ.delete(0);
      mWritten++;
      if (mWritten == TOTAL) begin
        mActive = 1'b0;
        expDone = 1'b1;
      end
    end
    if (expRd) begin
      pendQ.push_back(refGray(fifoQ[0]));
      fifoQ.delete(0);
      mRead++;
    end
    if (!wasActive && startReq) begin
      mActive  = 1'b1;
      mRead    = 0;
      mWritten = 0;
      framesStarted++;
    end
    #1;
    checkOutput("busy", 32'(busy), 32'(mActive));
    checkOutput("frame_done", 32'(frame_done), 32'(expDone));
    checkOutput("col", 32'(col), 32'(mRead % W));
    checkOutput("row", 32'(row), 32'((mRead / W) % H));
    if (pendQ.size() != 0) checkOutput("out_din_held", 32'(out_din), 32'(pendQ[0]));
    if (frame_done) doneCount++;
  endtask

  task automatic startFrame();
    startReq = 1'b1;
    applyStimulus();
    startReq = 1'b0;
  endtask

  task automatic finishFrame(int budget);
    int n;
    n = 0;
    while (mActive && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("frame_finished_in_budget", 32'(busy), 32'(0));
  endtask

  task automatic doReset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_frame_done", 32'(frame_done), 32'(0));
    checkOutput("rst_out_din", 32'(out_din), 32'(0));
    checkOutput("rst_col", 32'(col), 32'(0));
    checkOutput("rst_row", 32'(row), 32'(0));
    checkOutput("rst_in_rd_en", 32'(in_rd_en), 32'(0));
    checkOutput("rst_out_wr_en", 32'(out_wr_en), 32'(0));
    pendQ.delete();
    mActive  = 1'b0;
    mRead    = 0;
    mWritten = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] arithExp[5];
    int doneBase;
    int writeBase;
    int n;
    arithExp = '{8'hFF, 8'h00, 8'h00, 8'h55, 8'h20};
    reset = 1'b1; start = 1'b0; in_empty = 1'b1; in_dout = '0; out_full = 1'b0;
    starve = 0; fullReq = 0; startReq = 0;
    mActive = 0; mRead = 0; mWritten = 0; framesStarted = 0;
    doneCount = 0; writeCount = 0; testsRun = 0; failCount = 0;

    doReset();

    // Plain frame, no stalls
    loadRandom(TOTAL);
    doneBase = doneCount;
    startFrame();
    finishFrame(60);
    checkOutput("plain_done_pulses", 32'(doneCount - doneBase), 32'(1));
    repeat (2) applyStimulus();

    // Known-answer arithmetic, with extra data left in the FIFO afterwards
    fifoQ.push_back(24'hFFFFFF);
    fifoQ.push_back(24'h000000);
    fifoQ.push_back(24'h010100);
    fifoQ.push_back(24'hFF0000);
    fifoQ.push_back(24'h102030);
    loadRandom(3 + 2);
    wrLog.delete();
    startFrame();
    finishFrame(60);
    checkOutput("arith_write_count", 32'(wrLog.size()), 32'(TOTAL));
    for (int i = 0; i < 5; i++) checkOutput("arith_value", 32'(wrLog[i]), 32'(arithExp[i]));
    checkOutput("extra_left_in_fifo", 32'(fifoQ.size()), 32'(2));
    repeat (2) applyStimulus();
    fifoQ.delete();

    // Directed backpressure: hold full for 5 cycles after the first read
    loadRandom(TOTAL);
    startFrame();
    n = 0;
    while (mRead < 1 && n < 10) begin applyStimulus(); n++; end
    fullReq = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("bp_single_read", 32'(mRead), 32'(1));
    fullReq = 1'b0;
    finishFrame(60);

    // Random backpressure plus starvation toggling every other cycle
    loadRandom(TOTAL);
    startFrame();
    n = 0;
    while (mActive && n < 200) begin
      starve  = ~starve;
      fullReq = ($urandom_range(0, 3) == 0);
      applyStimulus();
      n++;
    end
    starve  = 1'b0;
    fullReq = 1'b0;
    checkOutput("starve_frame_finished", 32'(busy), 32'(0));

    // Reset mid-frame after 3 pixels, then a clean restart
    loadRandom(TOTAL);
    doneBase = doneCount;
    startFrame();
    n = 0;
    while (mRead < 3 && n < 20) begin applyStimulus(); n++; end
    doReset();
    repeat (3) applyStimulus();
    checkOutput("no_done_after_abort", 32'(doneCount - doneBase), 32'(0));
    loadRandom(3);
    startFrame();
    checkOutput("restart_col", 32'(col), 32'(0));
    checkOutput("restart_row", 32'(row), 32'(0));
    finishFrame(60);
    fifoQ.delete();

    // start held high across two back-to-back frames
    loadRandom(2 * TOTAL);
    doneBase      = doneCount;
    writeBase     = writeCount;
    framesStarted = 0;
    startReq      = 1'b1;
    n = 0;
    while (framesStarted < 2 && n < 100) begin applyStimulus(); n++; end
    startReq = 1'b0;
    finishFrame(60);
    checkOutput("b2b_done_pulses", 32'(doneCount - doneBase), 32'(2));
    checkOutput("b2b_writes", 32'(writeCount - writeBase), 32'(2 * TOTAL));
    repeat (2) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
